fft_pingpong_ram: RTL

Double-buffered (ping-pong) complex-sample frame buffer for the FFT_base2 datapath. It is the parametrised successor of the project's dual-port block RAM. Two banks of 2^CMD_WIDTH complex words each allow one frame to be written by the sample source while the previous frame is streamed out to the butterfly engine. The read order is sequential, or bit-reversed when compiled in.

---
 rtl/fft_pingpong_ram_if.sv | 24 ++
 rtl/fft_pingpong_ram.sv | 89 ++++++++
 2 files changed

// File: rtl/fft_pingpong_ram_if.sv
// Write/read handshake bundle of the ping-pong FFT frame buffer.
// The master modport is the sample source plus butterfly consumer; the slave modport is the buffer.
interface fft_pingpong_ram_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    WR_VALID;
  logic                    WR_READY;
  logic [2*DATA_WIDTH-1:0] WR_DATA;
  logic                    RD_VALID;
  logic                    RD_READY;
  logic [2*DATA_WIDTH-1:0] RD_DATA;
  logic                    RD_LAST;
  logic [1:0]              BANK_FULL;

  modport master (
    output WR_VALID, WR_DATA, RD_READY,
    input  WR_READY, RD_VALID, RD_DATA, RD_LAST, BANK_FULL
  );

  modport slave (
    input  WR_VALID, WR_DATA, RD_READY,
    output WR_READY, RD_VALID, RD_DATA, RD_LAST, BANK_FULL
  );
endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank ping-pong frame buffer: one frame fills while the previous one streams out.
// Define FFT_BITREV_EN to read each frame in bit-reversed address order (radix-2 DIT input order).
module fft_pingpong_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 10
) (
  input logic               CLK,
  input logic               RSTN,
  fft_pingpong_ram_if.slave bus
);
  localparam int N = 1 << CMD_WIDTH;
  localparam int W = 2 * DATA_WIDTH;

  logic [W-1:0]         mem [2][N];
  logic                 wbank, rbank;
  logic [CMD_WIDTH-1:0] wcnt, rcnt, raddr;
  logic [1:0]           full, full_nxt;
  logic                 rd_vld_p1, rd_last_p1;
  logic [W-1:0]         rd_data_p1;
  logic                 wr_fire, wr_done, rd_issue, rd_done;

`ifdef FFT_BITREV_EN
  function automatic logic [CMD_WIDTH-1:0] bitrev(input logic [CMD_WIDTH-1:0] a);
    logic [CMD_WIDTH-1:0] r;
    for (int i = 0; i < CMD_WIDTH; i++) r[i] = a[CMD_WIDTH-1-i];
    return r;
  endfunction

  assign raddr = bitrev(rcnt);
`else
  assign raddr = rcnt;
`endif

  always_comb begin
    wr_fire  = bus.WR_VALID && !full[wbank];
    wr_done  = wr_fire && (wcnt == '1);
    rd_issue = full[rbank] && (!rd_vld_p1 || bus.RD_READY);
    rd_done  = rd_issue && (rcnt == '1);
    full_nxt = full;
    // Set and clear always target different banks, so both may land in one cycle.
    if (rd_done) full_nxt[rbank] = 1'b0;
    if (wr_done) full_nxt[wbank] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (wr_fire) mem[wbank][wcnt] <= bus.WR_DATA;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wbank <= 1'b0;
      wcnt  <= '0;
      rbank <= 1'b0;
      rcnt  <= '0;
      full  <= 2'b00;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wcnt <= wcnt + 1'b1;
        if (wr_done) wbank <= ~wbank;
      end
      if (rd_issue) begin
        rcnt <= rcnt + 1'b1;
        if (rd_done) rbank <= ~rbank;
      end
    end
  end

  // Stage p1: registered read port; holds while the consumer stalls.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
      rd_data_p1 <= '0;
    end else if (rd_issue) begin
      rd_vld_p1  <= 1'b1;
      rd_last_p1 <= (rcnt == '1);
      rd_data_p1 <= mem[rbank][raddr];
    end else if (bus.RD_READY) begin
      rd_vld_p1  <= 1'b0;
    end
  end

  assign bus.WR_READY  = !full[wbank];
  assign bus.RD_VALID  = rd_vld_p1;
  assign bus.RD_LAST   = rd_last_p1;
  assign bus.RD_DATA   = rd_data_p1;
  assign bus.BANK_FULL = full;
endmodule
